// File: rtl/lsu_pkg.sv
// Shared types and helpers for the multi-cycle load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        BYT_1S = 3'd0,
        BYT_1U = 3'd1,
        BYT_2S = 3'd2,
        BYT_2U = 3'd3,
        BYT_4S = 3'd4,
        BYT_4U = 3'd5,
        BYT_8S = 3'd6,
        BYT_8U = 3'd7
    } ram_byt_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    function automatic int unsigned byt_size(input ram_byt_e e);
        case (e)
            BYT_1S, BYT_1U: return 32'd1;
            BYT_2S, BYT_2U: return 32'd2;
            BYT_4S, BYT_4U: return 32'd4;
            BYT_8S, BYT_8U: return 32'd8;
            default:        return 32'd1;
        endcase
    endfunction

    function automatic logic byt_signed(input ram_byt_e e);
        case (e)
            BYT_1S, BYT_2S, BYT_4S, BYT_8S: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store mask/data, load extract/extend, size/alignment error.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int OFF_W      = $clog2(MASK_WIDTH)
) (
    input  logic [OFF_W-1:0]      off,
    input  logic [2:0]            byt,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [MASK_WIDTH-1:0] mask,
    output logic [DATA_WIDTH-1:0] st_data,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  err
);

    int unsigned           size_s;
    logic                  sgn_s;
    logic                  sign_bit_s;
    logic [OFF_W-1:0]      size_m1_s;
    logic [MASK_WIDTH-1:0] lane_s;
    logic [DATA_WIDTH-1:0] shifted_s;

    // Lane mask, store shift, load extract with sign/zero extension and error detection
    always_comb begin
        size_s     = byt_size(ram_byt_e'(byt));
        sgn_s      = byt_signed(ram_byt_e'(byt));
        size_m1_s  = OFF_W'(size_s - 32'd1);
        err        = (size_s > MASK_WIDTH) || (|(off & size_m1_s));
        lane_s     = {MASK_WIDTH{1'b0}};
        sign_bit_s = 1'b0;
        ld_data    = {DATA_WIDTH{1'b0}};
        shifted_s  = rd_data >> {off, 3'b000};
        for (int i = 0; i < MASK_WIDTH; i++) begin
            lane_s[i]  = (i < size_s);
            // Top byte of the access supplies the sign bit
            sign_bit_s = (i == size_s - 32'd1) ? shifted_s[8*i+7] : sign_bit_s;
        end
        for (int i = 0; i < MASK_WIDTH; i++) begin
            ld_data[8*i +: 8] = lane_s[i] ? shifted_s[8*i +: 8] : {8{sgn_s & sign_bit_s}};
        end
        mask    = lane_s << off;
        st_data = wr_data << {off, 3'b000};
    end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: request handshake, RAM req/ack/rd_valid sequencing, registered results.
module lsu_mc
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_lsu_valid,
    output logic                  o_lsu_ready,
    input  logic                  i_lsu_rd_en,
    input  logic                  i_lsu_wr_en,
    input  logic [2:0]            i_lsu_byt,
    input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
    input  logic [DATA_WIDTH-1:0] i_lsu_wr_data,
    output logic                  o_lsu_ram_req,
    output logic                  o_lsu_ram_we,
    output logic [ADDR_WIDTH-1:0] o_lsu_ram_addr,
    output logic [DATA_WIDTH-1:0] o_lsu_ram_wr_data,
    output logic [MASK_WIDTH-1:0] o_lsu_ram_wr_mask,
    input  logic                  i_ram_ack,
    input  logic                  i_ram_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
    output logic                  o_lsu_done,
    output logic [DATA_WIDTH-1:0] o_lsu_gpr_wr_data,
    output logic                  o_lsu_err
);

    localparam int OFF_W = $clog2(MASK_WIDTH);

    lsu_state_e            state_r, state_nxt_s;
    logic [OFF_W-1:0]      off_r;
    logic [2:0]            byt_r;
    logic                  rd_r, wr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;

    logic                  ready_r, ram_req_r, ram_we_r, done_r, err_r;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [DATA_WIDTH-1:0] ram_wr_data_r, gpr_r;
    logic [MASK_WIDTH-1:0] ram_mask_r;

    logic                  idle_s, accept_s, access_s, store_s, load_s, req_err_s;
    logic [OFF_W-1:0]      sel_off_s;
    logic [2:0]            sel_byt_s;
    logic                  sel_rd_s, sel_wr_s;
    logic [DATA_WIDTH-1:0] sel_wr_data_s;
    logic [MASK_WIDTH-1:0] mask_s;
    logic [DATA_WIDTH-1:0] st_data_s, ld_data_s;
    logic                  align_err_s;

    // In IDLE the steering works on the incoming request, afterwards on the captured one
    always_comb begin
        idle_s        = (state_r == IDLE);
        accept_s      = i_lsu_valid & ready_r;
        sel_off_s     = idle_s ? i_lsu_addr[OFF_W-1:0] : off_r;
        sel_byt_s     = idle_s ? i_lsu_byt : byt_r;
        sel_rd_s      = idle_s ? i_lsu_rd_en : rd_r;
        sel_wr_s      = idle_s ? i_lsu_wr_en : wr_r;
        sel_wr_data_s = idle_s ? i_lsu_wr_data : wr_data_r;
        access_s      = sel_rd_s | sel_wr_s;
        store_s       = sel_wr_s;
        load_s        = sel_rd_s & ~sel_wr_s;
        req_err_s     = access_s & align_err_s;
    end

    lsu_align #(
        .DATA_WIDTH(DATA_WIDTH),
        .MASK_WIDTH(MASK_WIDTH),
        .OFF_W     (OFF_W)
    ) u_align (
        .off    (sel_off_s),
        .byt    (sel_byt_s),
        .wr_data(sel_wr_data_s),
        .rd_data(i_ram_rd_data),
        .mask   (mask_s),
        .st_data(st_data_s),
        .ld_data(ld_data_s),
        .err    (align_err_s)
    );

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (req_err_s || !access_s) ? DONE : REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (i_ram_ack) begin
                    state_nxt_s = (store_s || i_ram_rd_valid) ? DONE : WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (i_ram_rd_valid) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, captured request fields and registered outputs
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_r       <= IDLE;
            off_r         <= {OFF_W{1'b0}};
            byt_r         <= 3'd0;
            rd_r          <= 1'b0;
            wr_r          <= 1'b0;
            wr_data_r     <= {DATA_WIDTH{1'b0}};
            ready_r       <= 1'b1;
            ram_req_r     <= 1'b0;
            ram_we_r      <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            ram_addr_r    <= {ADDR_WIDTH{1'b0}};
            ram_wr_data_r <= {DATA_WIDTH{1'b0}};
            ram_mask_r    <= {MASK_WIDTH{1'b0}};
            gpr_r         <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            ready_r   <= (state_nxt_s == IDLE);
            ram_req_r <= (state_nxt_s == REQ);
            ram_we_r  <= (state_nxt_s == REQ) & store_s;
            done_r    <= (state_nxt_s == DONE);
            err_r     <= (state_nxt_s == DONE) & idle_s & req_err_s;
            // Load data is taken from the RAM bus in the cycle rd_valid is seen
            gpr_r     <= ((state_nxt_s == DONE) && !idle_s && load_s) ? ld_data_s
                                                                     : {DATA_WIDTH{1'b0}};
            if (accept_s) begin
                off_r         <= i_lsu_addr[OFF_W-1:0];
                byt_r         <= i_lsu_byt;
                rd_r          <= i_lsu_rd_en;
                wr_r          <= i_lsu_wr_en;
                wr_data_r     <= i_lsu_wr_data;
                ram_addr_r    <= {i_lsu_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                ram_wr_data_r <= i_lsu_wr_en ? st_data_s : {DATA_WIDTH{1'b0}};
                ram_mask_r    <= i_lsu_wr_en ? mask_s : {MASK_WIDTH{1'b0}};
            end
        end
    end

    assign o_lsu_ready       = ready_r;
    assign o_lsu_ram_req     = ram_req_r;
    assign o_lsu_ram_we      = ram_we_r;
    assign o_lsu_ram_addr    = ram_addr_r;
    assign o_lsu_ram_wr_data = ram_wr_data_r;
    assign o_lsu_ram_wr_mask = ram_mask_r;
    assign o_lsu_done        = done_r;
    assign o_lsu_gpr_wr_data = gpr_r;
    assign o_lsu_err         = err_r;

endmodule
